hit_rec_build: RTL

HIT_REC_BUILD -- requirements
Module: hit_rec_build

---
 rtl/hit_pkg.sv | 28 ++
 rtl/hit_rec_fifo.sv | 53 +++++
 rtl/hit_rec_build.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/hit_pkg.sv
// Shared definitions for the hit record builder: FSM encodings, record layout
// and flag bit positions.
package hit_pkg;

   // Record builder FSM encodings
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACC  = 2'd1;
   localparam logic [1:0] S_PUSH = 2'd2;

   // Stored record width: id16 + time32 + sum32 + peak16 + width16 + flag3 + 14 reserved
   localparam int REC_W = 129;

   // Bit positions inside the 3-bit flag field
   localparam int FLG_FORCE   = 0;
   localparam int FLG_SUM_SAT = 1;
   localparam int FLG_WID_SAT = 2;

   typedef struct packed {
      logic [13:0] rsvd;
      logic [2:0]  flag;
      logic [15:0] width;
      logic [15:0] peak;
      logic [31:0] sum;
      logic [31:0] tstamp;
      logic [15:0] id;
   } rec_t;

endpackage

// File: rtl/hit_rec_fifo.sv
// First-word-fall-through record FIFO. The head entry is always visible on
// rd_data; a write into a full FIFO is accepted only when a read retires the
// head in the same cycle. Handshake: a read happens on rd_en & !empty, a write
// happens on wr_en & (!full | read).
module hit_rec_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 129,
   localparam int AW = $clog2(DEPTH),
   localparam int LW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [LW-1:0]    level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = mem[rd_ptr];

   // Storage array; data only, no reset needed
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // Pointers and occupancy; depth is a power of two so pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         if (do_wr && !do_rd)      level <= level + LW'(1);
         else if (do_rd && !do_wr) level <= level - LW'(1);
      end
   end

endmodule

// File: rtl/hit_rec_build.sv
// Hit record builder: integrates smoothed samples over each hit reported by the
// hit FSM, stamps the record with the start time and id, and queues it in a
// FWFT FIFO. Output handshake: a record is consumed on rec_vld & rec_rdy.
module hit_rec_build
   import hit_pkg::*;
#(
   parameter int REC_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        rst,
   input  logic [15:0] sm_data,
   input  logic        sm_vld,
   input  logic        stu_now_hit,
   input  logic        force_end,
   input  logic [15:0] stu_hit_id,
   input  logic [15:0] cfg_base,
   input  logic        cfg_en,
   input  logic        rec_rdy,
   output logic        rec_vld,
   output logic [15:0] rec_id,
   output logic [31:0] rec_time,
   output logic [31:0] rec_sum,
   output logic [15:0] rec_peak,
   output logic [15:0] rec_width,
   output logic [2:0]  rec_flag,
   output logic [4:0]  stu_rec_lvl,
   output logic [15:0] stu_drop_cnt,
   output logic [1:0]  dbg_state
);

   localparam int LW = $clog2(REC_DEPTH) + 1;

   logic [1:0]       state;
   logic [31:0]      ts;
   logic [15:0]      id_r;
   logic [31:0]      time_r;
   logic [31:0]      sum_r;
   logic [15:0]      peak_r;
   logic [15:0]      width_r;
   logic [2:0]       flag_r;
   logic [15:0]      clip;
   logic [32:0]      sum_ext;
   logic             wr_en;
   rec_t             wr_rec;
   rec_t             head;
   logic [REC_W-1:0] rd_data;
   logic             full;
   logic             empty;
   logic             pop;
   logic [LW-1:0]    level;
   logic             unused_rsvd;

   // Baseline-subtracted sample, clipped at zero
   always_comb begin
      clip = '0;
      if (sm_data > cfg_base) clip = sm_data - cfg_base;
   end

   assign sum_ext = {1'b0, sum_r} + {17'd0, clip};

   // Free-running timestamp, wraps at 2^32
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) ts <= '0;
      else     ts <= ts + 32'd1;
   end

   // Capture FSM and accumulators
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         id_r    <= '0;
         time_r  <= '0;
         sum_r   <= '0;
         peak_r  <= '0;
         width_r <= '0;
         flag_r  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cfg_en && stu_now_hit) begin
                  state             <= S_ACC;
                  time_r            <= ts;
                  id_r              <= stu_hit_id;
                  flag_r            <= '0;
                  flag_r[FLG_FORCE] <= force_end;
                  if (sm_vld) begin
                     sum_r   <= {16'd0, clip};
                     peak_r  <= sm_data;
                     width_r <= 16'd1;
                  end else begin
                     sum_r   <= '0;
                     peak_r  <= '0;
                     width_r <= '0;
                  end
               end
            end
            S_ACC: begin
               if (force_end) flag_r[FLG_FORCE] <= 1'b1;
               // The falling-edge cycle closes the hit; its sample is not taken
               if (!stu_now_hit) begin
                  state <= S_PUSH;
               end else if (sm_vld) begin
                  sum_r <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
                  if (sum_ext >= 33'h0_FFFF_FFFF) flag_r[FLG_SUM_SAT] <= 1'b1;
                  if (sm_data > peak_r) peak_r <= sm_data;
                  if (width_r != 16'hFFFF) width_r <= width_r + 16'd1;
                  if (width_r >= 16'hFFFE) flag_r[FLG_WID_SAT] <= 1'b1;
               end
            end
            S_PUSH:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Write strobe registered out of S_PUSH so the FIFO write lands one edge later
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) wr_en <= 1'b0;
      else     wr_en <= (state == S_PUSH);
   end

   // Record snapshot taken while the FSM sits in S_PUSH
   always_ff @(posedge clk_sys) begin
      if (state == S_PUSH) begin
         wr_rec <= '{rsvd: '0, flag: flag_r, width: width_r, peak: peak_r,
                     sum: sum_r, tstamp: time_r, id: id_r};
      end
   end

   assign rec_vld = !empty;
   assign pop     = rec_vld && rec_rdy;

   // Count records lost to a full FIFO, saturating
   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) stu_drop_cnt <= '0;
      else if (wr_en && full && !pop && stu_drop_cnt != 16'hFFFF)
         stu_drop_cnt <= stu_drop_cnt + 16'd1;
   end

   hit_rec_fifo #(
      .DEPTH (REC_DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk     (clk_sys),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_rec),
      .rd_en   (rec_rdy),
      .rd_data (rd_data),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   assign head        = rec_t'(rd_data);
   assign rec_id      = head.id;
   assign rec_time    = head.tstamp;
   assign rec_sum     = head.sum;
   assign rec_peak    = head.peak;
   assign rec_width   = head.width;
   assign rec_flag    = head.flag;
   assign unused_rsvd = ^head.rsvd;
   assign stu_rec_lvl = 5'(level);
   assign dbg_state   = state;

endmodule
